// File: rtl/cargador_instrucciones.sv
// Program loader: packs UART bytes (MSB first) into instruction words and writes them to instruction RAM.
// Optional macro LOADER_CHECKSUM_EN adds a trailing XOR checksum byte after the halt word.
module cargador_instrucciones #(
    parameter int len                = 32,
    parameter int LEN_DATA           = 8,
    parameter int cant_instrucciones = 64,
    parameter logic [len-1:0] HALT_WORD = 32'hFFFFFFFF
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  start,
    input  logic                                  rx_done,
    input  logic [LEN_DATA-1:0]                   uart_data_in,
    output logic [len-1:0]                        addr_mem_inst,
    output logic [len-1:0]                        ins_to_mem,
    output logic                                  write_enable_ram_inst,
    output logic                                  busy,
    output logic                                  done,
    output logic                                  error,
    output logic [$clog2(cant_instrucciones):0]   word_count,
    output logic [2:0]                            state_dbg
);

    localparam int BPW   = len / LEN_DATA;
    localparam int IDX_W = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int WC_W  = $clog2(cant_instrucciones) + 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RECV   = 3'd1,
        WRITE  = 3'd2,
        DONE_S = 3'd3,
        CHECK  = 3'd4
    } state_t;

    state_t               state;
    logic [IDX_W-1:0]     byte_idx;
    logic [len-1:0]       shift_reg;
    logic [len-1:0]       shifted;
    logic                 last_byte;
    logic                 mem_full;
`ifdef LOADER_CHECKSUM_EN
    logic [LEN_DATA-1:0]  csum;
`endif

    assign shifted   = {shift_reg[len-LEN_DATA-1:0], uart_data_in};
    assign last_byte = (byte_idx == IDX_W'(BPW - 1));
    assign mem_full  = ((word_count + WC_W'(1)) == WC_W'(cant_instrucciones));
    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state                 <= IDLE;
            addr_mem_inst         <= '0;
            ins_to_mem            <= '0;
            write_enable_ram_inst <= 1'b0;
            busy                  <= 1'b0;
            done                  <= 1'b0;
            error                 <= 1'b0;
            word_count            <= '0;
            byte_idx              <= '0;
            shift_reg             <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum                  <= '0;
`endif
        end else begin
            case (state)
                IDLE, DONE_S: begin
                    // A byte arriving together with start is deliberately dropped.
                    if (start) begin
                        state         <= RECV;
                        addr_mem_inst <= '0;
                        word_count    <= '0;
                        done          <= 1'b0;
                        error         <= 1'b0;
                        busy          <= 1'b1;
                        byte_idx      <= '0;
                        shift_reg     <= '0;
`ifdef LOADER_CHECKSUM_EN
                        csum          <= '0;
`endif
                    end
                end
                RECV: begin
                    if (rx_done) begin
                        shift_reg <= shifted;
`ifdef LOADER_CHECKSUM_EN
                        csum      <= csum ^ uart_data_in;
`endif
                        if (last_byte) begin
                            byte_idx              <= '0;
                            ins_to_mem            <= shifted;
                            write_enable_ram_inst <= 1'b1;
                            state                 <= WRITE;
                        end else begin
                            byte_idx <= byte_idx + IDX_W'(1);
                        end
                    end
                end
                WRITE: begin
                    write_enable_ram_inst <= 1'b0;
                    addr_mem_inst         <= addr_mem_inst + len'(1);
                    word_count            <= word_count + WC_W'(1);
                    if (ins_to_mem == HALT_WORD) begin
`ifdef LOADER_CHECKSUM_EN
                        // A byte landing on the halt strobe is already the checksum byte.
                        if (rx_done) begin
                            state <= DONE_S;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            error <= (uart_data_in != csum);
                        end else begin
                            state <= CHECK;
                        end
`else
                        state <= DONE_S;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        error <= 1'b0;
`endif
                    end else if (mem_full) begin
                        state <= DONE_S;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        error <= 1'b1;
                    end else begin
                        state <= RECV;
                        // Keep a byte that arrived during the strobe as byte 0 of the next word.
                        if (rx_done) begin
                            shift_reg <= shifted;
                            byte_idx  <= IDX_W'(1);
`ifdef LOADER_CHECKSUM_EN
                            csum      <= csum ^ uart_data_in;
`endif
                        end
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                CHECK: begin
                    if (rx_done) begin
                        state <= DONE_S;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        error <= (uart_data_in != csum);
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule
